// File: rtl/sha_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha_pkg : shared constants and encodings for the SHA-256 front end  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package sha_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 16;
    localparam int LEN_POS     = 56;

    typedef logic [1:0] last_next_t;
    localparam last_next_t LN_DATA  = 2'b00;
    localparam last_next_t LN_FINAL = 2'b01;
    localparam last_next_t LN_SPILL = 2'b10;

    typedef logic [2:0] pad_state_t;
    localparam pad_state_t S_MSG   = 3'd0;
    localparam pad_state_t S_PAD80 = 3'd1;
    localparam pad_state_t S_ZERO  = 3'd2;
    localparam pad_state_t S_LEN   = 3'd3;
    localparam pad_state_t S_DRAIN = 3'd4;

endpackage
`default_nettype wire

// File: rtl/sha_msg_padder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha_msg_padder_if : byte-in / word-out handshake bundle            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface sha_msg_padder_if;
    import sha_pkg::*;

    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [WORD_W-1:0] out_word;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_index;
    logic              out_last_word;
    last_next_t        out_last_next;
    logic              busy;

    modport slave (
        input  in_byte, in_valid, in_last, out_ready,
        output in_ready, out_word, out_valid, out_index, out_last_word, out_last_next, busy
    );

    modport master (
        output in_byte, in_valid, in_last, out_ready,
        input  in_ready, out_word, out_valid, out_index, out_last_word, out_last_next, busy
    );

endinterface
`default_nettype wire

// File: rtl/sha_word_packer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha_word_packer : MSB-first byte-to-word assembler + output reg    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sha_word_packer
    import sha_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              byte_valid,
    input  wire logic [7:0]        byte_data,
    input  wire logic [3:0]        byte_index,
    input  wire last_next_t        byte_ln,
    input  wire logic              byte_last,
    output logic                   en,
    output logic [WORD_W-1:0]      out_word,
    output logic                   out_valid,
    input  wire logic              out_ready,
    output logic [3:0]             out_index,
    output logic                   out_last_word,
    output last_next_t             out_last_next
);

    logic [23:0] acc;
    logic [1:0]  cnt;

    assign en = !out_valid || out_ready;

    // Sidebands are taken from the 4th byte; words never straddle a block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc           <= '0;
            cnt           <= '0;
            out_word      <= '0;
            out_valid     <= 1'b0;
            out_index     <= '0;
            out_last_word <= 1'b0;
            out_last_next <= LN_DATA;
        end else begin
            if (byte_valid) begin
                cnt <= cnt + 2'd1;
                acc <= {acc[15:0], byte_data};
            end
            if (byte_valid && cnt == 2'd3) begin
                out_word      <= {acc, byte_data};
                out_valid     <= 1'b1;
                out_index     <= byte_index;
                out_last_word <= byte_last;
                out_last_next <= byte_ln;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sha_msg_padder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha_msg_padder : SHA-256 message padding, bytes in, 16-word blocks  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sha_msg_padder
    import sha_pkg::*;
#(
    parameter int LEN_W       = 64,
    parameter int BLOCK_BYTES = 64
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sha_msg_padder_if.slave   bus
);

    localparam int POS_W = $clog2(BLOCK_BYTES);
    localparam logic [POS_W-1:0] POS_PRE_LEN = POS_W'(LEN_POS - 1);
    localparam logic [POS_W-1:0] POS_LAST    = POS_W'(BLOCK_BYTES - 1);

    pad_state_t       state;
    logic [POS_W-1:0] pos;
    logic [LEN_W-1:0] bitcnt;
    logic             spill;
    logic [2:0]       len_idx;
    logic             busy_q;

    logic             en;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             spill_cur;
    last_next_t       byte_ln;
    logic             byte_last;
    logic [63:0]      len64;
    logic [63:0]      len_sh;

    assign bus.in_ready = rst && (state == S_MSG) && en;
    assign bus.busy     = busy_q;

    always_comb begin
        len64              = '0;
        len64[LEN_W-1:0]   = bitcnt;
        len_sh             = len64 << {len_idx, 3'b000};
        // The 0x80 byte decides spill from the position it lands on.
        spill_cur          = (state == S_PAD80) ? (pos > POS_PRE_LEN) : spill;
        byte_valid         = 1'b0;
        byte_data          = 8'h00;
        case (state)
            S_MSG: begin
                byte_valid = bus.in_valid && en;
                byte_data  = bus.in_byte;
            end
            S_PAD80: begin
                byte_valid = en;
                byte_data  = 8'h80;
            end
            S_ZERO: byte_valid = en;
            S_LEN: begin
                byte_valid = en;
                byte_data  = len_sh[63:56];
            end
            default: ;
        endcase
        byte_ln   = (state == S_MSG) ? LN_DATA : (spill_cur ? LN_SPILL : LN_FINAL);
        byte_last = (state == S_LEN) && (len_idx == 3'd7);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_MSG;
            pos     <= '0;
            bitcnt  <= '0;
            spill   <= 1'b0;
            len_idx <= '0;
            busy_q  <= 1'b0;
        end else begin
            if (byte_valid)
                pos <= pos + POS_W'(1);
            case (state)
                S_MSG: if (byte_valid) begin
                    bitcnt <= bitcnt + LEN_W'(8);
                    busy_q <= 1'b1;
                    if (bus.in_last)
                        state <= S_PAD80;
                end
                S_PAD80: if (byte_valid) begin
                    spill <= spill_cur && (pos != POS_LAST);
                    state <= (pos == POS_PRE_LEN) ? S_LEN : S_ZERO;
                end
                S_ZERO: if (byte_valid) begin
                    if (pos == POS_LAST)
                        spill <= 1'b0;
                    if (pos == POS_PRE_LEN && !spill)
                        state <= S_LEN;
                end
                S_LEN: if (byte_valid) begin
                    len_idx <= len_idx + 3'd1;
                    if (len_idx == 3'd7)
                        state <= S_DRAIN;
                end
                S_DRAIN: if (bus.out_valid && bus.out_ready && bus.out_last_word) begin
                    bitcnt <= '0;
                    pos    <= '0;
                    busy_q <= 1'b0;
                    state  <= S_MSG;
                end
                default: state <= S_MSG;
            endcase
        end
    end

    sha_word_packer u_packer (
        .clk           (clk),
        .rst           (rst),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_index    (pos[POS_W-1:2]),
        .byte_ln       (byte_ln),
        .byte_last     (byte_last),
        .en            (en),
        .out_word      (bus.out_word),
        .out_valid     (bus.out_valid),
        .out_ready     (bus.out_ready),
        .out_index     (bus.out_index),
        .out_last_word (bus.out_last_word),
        .out_last_next (bus.out_last_next)
    );

endmodule
`default_nettype wire

// File: tb/tb_sha_msg_padder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sha_msg_padder : directed vectors against a padding model       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_sha_msg_padder;
    import sha_pkg::*;

    localparam int BUDGET = 3000;

    typedef struct {
        int          kind;
        int          wn;
        logic [31:0] word;
        logic [1:0]  ln;
        logic        last;
    } chk_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sha_msg_padder_if bus ();

    sha_msg_padder #(.LEN_W(64), .BLOCK_BYTES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  msg [0:127];
    int          msg_len;
    logic [31:0] cap_word [0:63];
    logic [3:0]  cap_idx  [0:63];
    logic [1:0]  cap_ln   [0:63];
    logic        cap_last [0:63];
    int          n_cap;
    chk_t        chk [$];

    task automatic load_msg(input int kind);
        case (kind)
            0: begin msg_len = 3;  msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; end
            1: begin msg_len = 5;  msg[0] = 8'h68; msg[1] = 8'h65; msg[2] = 8'h6c;
                                   msg[3] = 8'h6c; msg[4] = 8'h6f; end
            2: begin msg_len = 55; for (int i = 0; i < 55; i++) msg[i] = 8'h41; end
            3: begin msg_len = 56; for (int i = 0; i < 56; i++) msg[i] = 8'h41; end
            4: begin msg_len = 64; for (int i = 0; i < 64; i++) msg[i] = 8'h42; end
            default: begin msg_len = 63; for (int i = 0; i < 63; i++) msg[i] = 8'h43; end
        endcase
    endtask

    // Reference padding: message, 0x80, zeros, 64-bit big-endian bit length.
    function automatic logic [7:0] exp_byte(input int i);
        int          tot;
        logic [63:0] bits;
        logic [63:0] sh;
        tot  = ((msg_len + 72) / 64) * 64;
        bits = 64'(msg_len) * 64'd8;
        if (i < msg_len) return msg[i];
        if (i == msg_len) return 8'h80;
        if (i >= tot - 8) begin
            sh = bits >> (8 * (tot - 1 - i));
            return sh[7:0];
        end
        return 8'h00;
    endfunction

    task automatic drive_msg();
        int i = 0;
        int t = 0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b1;
        while (i < msg_len && t < BUDGET) begin
            @(negedge clk);
            t++;
            bus.in_valid = 1'b1;
            bus.in_byte  = msg[i];
            bus.in_last  = (i == msg_len - 1);
            #2;
            if (bus.in_ready) i++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n_vec++;
        if (i != msg_len) begin
            n_err++;
            $display("FAIL drive: accepted %0d bytes, required %0d", i, msg_len);
        end
    endtask

    task automatic collect(input int nw, input bit toggle);
        int          t = 0;
        bit          stalled = 1'b0;
        logic [31:0] pw = '0;
        logic [3:0]  pi = '0;
        n_cap = 0;
        while (n_cap < nw && t < BUDGET) begin
            @(negedge clk);
            t++;
            bus.out_ready = toggle ? t[0] : 1'b1;
            #2;
            if (stalled) begin
                n_vec++;
                if (!bus.out_valid || bus.out_word !== pw || bus.out_index !== pi) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b %h idx %0d, required v=1 %h idx %0d",
                             bus.out_valid, bus.out_word, bus.out_index, pw, pi);
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            if (stalled) begin
                pw = bus.out_word;
                pi = bus.out_index;
                n_vec++;
                if (bus.in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL in_ready_stall: got %b, required 0", bus.in_ready);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                cap_word[n_cap] = bus.out_word;
                cap_idx[n_cap]  = bus.out_index;
                cap_ln[n_cap]   = bus.out_last_next;
                cap_last[n_cap] = bus.out_last_word;
                n_cap++;
            end
        end
        n_vec++;
        if (n_cap != nw) begin
            n_err++;
            $display("FAIL word_count: got %0d words, required %0d", n_cap, nw);
        end
    endtask

    task automatic run_msg(input int kind, input bit toggle);
        int          nb;
        int          nw;
        logic [31:0] ew;
        logic [1:0]  eln;
        logic        elast;
        logic [3:0]  eidx;
        load_msg(kind);
        nb = (msg_len + 72) / 64;
        nw = nb * 16;
        fork
            drive_msg();
            collect(nw, toggle);
        join
        for (int w = 0; w < n_cap; w++) begin
            ew    = {exp_byte(4*w), exp_byte(4*w+1), exp_byte(4*w+2), exp_byte(4*w+3)};
            eln   = (4*w + 3 < msg_len) ? LN_DATA : ((w / 16 < nb - 1) ? LN_SPILL : LN_FINAL);
            elast = (w == nw - 1);
            eidx  = 4'(w % 16);
            n_vec++;
            if (cap_word[w] !== ew || cap_idx[w] !== eidx || cap_ln[w] !== eln || cap_last[w] !== elast) begin
                n_err++;
                $display("FAIL word k%0d w%0d: got %h idx %0d ln %b last %b, required %h idx %0d ln %b last %b",
                         kind, w, cap_word[w], cap_idx[w], cap_ln[w], cap_last[w], ew, eidx, eln, elast);
            end
        end
        foreach (chk[c]) begin
            if (chk[c].kind == kind) begin
                n_vec++;
                if (chk[c].wn >= n_cap) begin
                    n_err++;
                    $display("FAIL chk k%0d w%0d: word missing, required %h", kind, chk[c].wn, chk[c].word);
                end else if (cap_word[chk[c].wn] !== chk[c].word || cap_ln[chk[c].wn] !== chk[c].ln ||
                             cap_last[chk[c].wn] !== chk[c].last) begin
                    n_err++;
                    $display("FAIL chk k%0d w%0d: got %h ln %b last %b, required %h ln %b last %b",
                             kind, chk[c].wn, cap_word[chk[c].wn], cap_ln[chk[c].wn], cap_last[chk[c].wn],
                             chk[c].word, chk[c].ln, chk[c].last);
                end
            end
        end
        @(negedge clk);
        #2;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after k%0d: got busy %b out_valid %b, required 0 0", kind, bus.busy, bus.out_valid);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got in_ready %b out_valid %b busy %b, required 0 0 0",
                     tag, bus.in_ready, bus.out_valid, bus.busy);
        end
        n_vec++;
        if (bus.out_word !== 32'h0 || bus.out_index !== 4'h0 || bus.out_last_word !== 1'b0 ||
            bus.out_last_next !== 2'b00) begin
            n_err++;
            $display("FAIL %s_regs: got %h idx %0d last %b ln %b, required 0 0 0 00",
                     tag, bus.out_word, bus.out_index, bus.out_last_word, bus.out_last_next);
        end
    endtask

    initial begin
        chk.push_back('{0,  0, 32'h61626380, 2'b01, 1'b0});
        chk.push_back('{0, 14, 32'h00000000, 2'b01, 1'b0});
        chk.push_back('{0, 15, 32'h00000018, 2'b01, 1'b1});
        chk.push_back('{1,  0, 32'h68656c6c, 2'b00, 1'b0});
        chk.push_back('{1,  1, 32'h6f800000, 2'b01, 1'b0});
        chk.push_back('{1, 15, 32'h00000028, 2'b01, 1'b1});
        chk.push_back('{2, 12, 32'h41414141, 2'b00, 1'b0});
        chk.push_back('{2, 13, 32'h41414180, 2'b01, 1'b0});
        chk.push_back('{2, 15, 32'h000001B8, 2'b01, 1'b1});
        chk.push_back('{3, 13, 32'h41414141, 2'b00, 1'b0});
        chk.push_back('{3, 14, 32'h80000000, 2'b10, 1'b0});
        chk.push_back('{3, 15, 32'h00000000, 2'b10, 1'b0});
        chk.push_back('{3, 16, 32'h00000000, 2'b01, 1'b0});
        chk.push_back('{3, 31, 32'h000001C0, 2'b01, 1'b1});
        chk.push_back('{4, 15, 32'h42424242, 2'b00, 1'b0});
        chk.push_back('{4, 16, 32'h80000000, 2'b01, 1'b0});
        chk.push_back('{4, 31, 32'h00000200, 2'b01, 1'b1});
        chk.push_back('{5, 15, 32'h43434380, 2'b10, 1'b0});
        chk.push_back('{5, 16, 32'h00000000, 2'b01, 1'b0});
        chk.push_back('{5, 31, 32'h000001F8, 2'b01, 1'b1});

        bus.in_byte   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;

        for (int k = 0; k < 6; k++) run_msg(k, 1'b0);
        run_msg(0, 1'b1);

        // Abandon a message two bytes in via reset.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h11;
        @(negedge clk);
        bus.in_byte  = 8'h22;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        n_vec++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_mid: got %b, required 1", bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_reset_outputs("reset_mid");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #2;
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_after_reset: got %b, required 0", bus.busy);
        end

        run_msg(0, 1'b0);
        run_msg(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
